// File: rtl/frame_uploader_nbuf.sv
// frame_uploader_nbuf: packs camera pixels from a load queue into memory words
// and writes whole frames as fixed-length bursts into a ring of frame buffers,
// skipping the buffer currently held by the reader.
// Optional statistics outputs (frame_count, drop_count) are enabled by
// defining FRAME_UPLOADER_STATS_EN.
module frame_uploader_nbuf #(
  parameter int unsigned PIXEL_W     = 16,
  parameter int unsigned MEM_DATA_W  = 32,
  parameter int unsigned BURST_BEATS = 8,
  parameter int unsigned NUM_BUFFERS = 3,
  parameter int unsigned FRAME_WORDS = 38400,
  parameter int unsigned ADDR_W      = 21,
  parameter int unsigned BASE_ADDR   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  init_done,
  input  logic                  mem_busy,
  output logic                  load_rd_en,
  input  logic                  load_queue_empty,
  input  logic [PIXEL_W:0]      load_queue_data,
  output logic                  cmd,
  output logic                  cmd_en,
  output logic [ADDR_W-1:0]     addr,
  output logic [MEM_DATA_W-1:0] wr_data,
  input  logic                  rd_lock_en,
  input  logic [2:0]            rd_lock_buf,
  output logic                  frame_done,
  output logic [2:0]            last_buf,
  output logic [2:0]            wr_buf,
  output logic                  overrun
`ifdef FRAME_UPLOADER_STATS_EN
  ,
  output logic [15:0]           frame_count,
  output logic [15:0]           drop_count
`endif
);

  localparam int unsigned PPW       = MEM_DATA_W / PIXEL_W;
  localparam int unsigned CAP       = BURST_BEATS * PPW;
  localparam int unsigned NBURST    = FRAME_WORDS / BURST_BEATS;
  localparam int unsigned STAGE_W   = CAP * PIXEL_W;
  localparam int unsigned PIX_CNT_W = $clog2(CAP + 1);
  localparam int unsigned PIX_IX_W  = (CAP > 1) ? $clog2(CAP) : 1;
  localparam int unsigned BIDX_W    = $clog2(NBURST + 1);
  localparam int unsigned BEAT_W    = $clog2(BURST_BEATS + 1);
  localparam int unsigned BEAT_IX_W = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_SOF, S_FILL, S_BURST, S_FRAME_END
  } state_t;

  state_t                 state_q, state_d;
  logic                   rd_pend_q;
  logic [PIX_CNT_W-1:0]   pix_cnt_q;
  logic [BIDX_W-1:0]      burst_idx_q;
  logic [BEAT_W-1:0]      beat_q;
  logic                   active_q;
  logic                   marker_end_q;
  logic                   after_full_q;
  logic [STAGE_W-1:0]     stage_q;

  logic                   cap_c, mark_c, rd_issue_c, burst_go_c, burst_end_c;
  logic                   last_burst_c;
  logic [2:0]             nb1_c, nb2_c, buf_next_c;
  logic [ADDR_W-1:0]      addr_c;
  logic [MEM_DATA_W-1:0]  beat_word_c;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (init_done) state_d = S_WAIT_SOF;
      S_WAIT_SOF:  if (cap_c && mark_c) state_d = S_FILL;
      S_FILL: begin
        if (cap_c) begin
          if (mark_c)
            state_d = (pix_cnt_q == '0) ? S_FRAME_END : S_BURST;
          else if (pix_cnt_q == PIX_CNT_W'(CAP - 1))
            state_d = S_BURST;
        end
      end
      S_BURST:     if (burst_end_c)
                     state_d = (marker_end_q || last_burst_c) ? S_FRAME_END : S_FILL;
      S_FRAME_END: state_d = marker_end_q ? S_FILL : S_WAIT_SOF;
      default:     state_d = S_IDLE;
    endcase
  end

  // Output decode: read issue, burst strobes, address and buffer selection
  always_comb begin
    cap_c        = rd_pend_q;
    mark_c       = load_queue_data[PIXEL_W];
    rd_issue_c   = init_done && !load_queue_empty && !load_rd_en && !rd_pend_q &&
                   ((state_q == S_WAIT_SOF) ||
                    ((state_q == S_FILL) && (pix_cnt_q < PIX_CNT_W'(CAP))));
    burst_go_c   = (state_q == S_BURST) && !active_q && !mem_busy && init_done;
    burst_end_c  = (state_q == S_BURST) && active_q && (beat_q == BEAT_W'(BURST_BEATS));
    last_burst_c = (burst_idx_q == BIDX_W'(NBURST - 1));
    nb1_c        = (wr_buf == 3'(NUM_BUFFERS - 1)) ? 3'd0 : wr_buf + 3'd1;
    nb2_c        = (nb1_c == 3'(NUM_BUFFERS - 1)) ? 3'd0 : nb1_c + 3'd1;
    buf_next_c   = (rd_lock_en && (nb1_c == rd_lock_buf)) ? nb2_c : nb1_c;
    addr_c       = ADDR_W'(BASE_ADDR) +
                   ADDR_W'(wr_buf) * ADDR_W'(FRAME_WORDS) +
                   ADDR_W'(burst_idx_q) * ADDR_W'(BURST_BEATS);
    beat_word_c  = stage_q[int'(beat_q[BEAT_IX_W-1:0]) * MEM_DATA_W +: MEM_DATA_W];
  end

  // Datapath: queue reads, pixel packing, burst beats and frame bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_rd_en   <= 1'b0;
      rd_pend_q    <= 1'b0;
      cmd          <= 1'b0;
      cmd_en       <= 1'b0;
      addr         <= '0;
      wr_data      <= '0;
      frame_done   <= 1'b0;
      overrun      <= 1'b0;
      wr_buf       <= 3'd0;
      last_buf     <= 3'd0;
      pix_cnt_q    <= '0;
      burst_idx_q  <= '0;
      beat_q       <= '0;
      active_q     <= 1'b0;
      marker_end_q <= 1'b0;
      after_full_q <= 1'b0;
      stage_q      <= '0;
    end else begin
      load_rd_en <= rd_issue_c;
      rd_pend_q  <= load_rd_en;
      frame_done <= 1'b0;
      cmd_en     <= 1'b0;

      if ((state_q == S_WAIT_SOF) && cap_c) begin
        if (mark_c) after_full_q <= 1'b0;
        else if (after_full_q) overrun <= 1'b1;
      end

      if ((state_q == S_FILL) && cap_c) begin
        if (mark_c) begin
          marker_end_q <= 1'b1;
        end else begin
          stage_q[int'(pix_cnt_q[PIX_IX_W-1:0]) * PIXEL_W +: PIXEL_W] <=
            load_queue_data[PIXEL_W-1:0];
          pix_cnt_q <= pix_cnt_q + PIX_CNT_W'(1);
        end
      end

      if (burst_go_c) begin
        cmd      <= 1'b1;
        cmd_en   <= 1'b1;
        addr     <= addr_c;
        wr_data  <= stage_q[MEM_DATA_W-1:0];
        active_q <= 1'b1;
        beat_q   <= BEAT_W'(1);
      end else if (burst_end_c) begin
        cmd         <= 1'b0;
        active_q    <= 1'b0;
        beat_q      <= '0;
        stage_q     <= '0;
        pix_cnt_q   <= '0;
        burst_idx_q <= burst_idx_q + BIDX_W'(1);
      end else if ((state_q == S_BURST) && active_q) begin
        wr_data <= beat_word_c;
        beat_q  <= beat_q + BEAT_W'(1);
      end

      if (state_q == S_FRAME_END) begin
        frame_done   <= 1'b1;
        last_buf     <= wr_buf;
        wr_buf       <= buf_next_c;
        burst_idx_q  <= '0;
        after_full_q <= !marker_end_q;
        marker_end_q <= 1'b0;
      end
    end
  end

`ifdef FRAME_UPLOADER_STATS_EN
  // Frame counter wraps; drop counter saturates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_count <= 16'd0;
      drop_count  <= 16'd0;
    end else begin
      if (state_q == S_FRAME_END) frame_count <= frame_count + 16'd1;
      if ((state_q == S_WAIT_SOF) && cap_c && !mark_c && (drop_count != 16'hFFFF))
        drop_count <= drop_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_frame_uploader_nbuf.sv
// Directed self-checking bench for frame_uploader_nbuf (small 16-word frames).
module tb_frame_uploader_nbuf;

  localparam int unsigned PIXEL_W     = 16;
  localparam int unsigned MEM_DATA_W  = 32;
  localparam int unsigned BURST_BEATS = 8;
  localparam int unsigned NUM_BUFFERS = 3;
  localparam int unsigned FRAME_WORDS = 16;
  localparam int unsigned ADDR_W      = 21;
  localparam int unsigned BASE_ADDR   = 32'h100;

  logic                  clk;
  logic                  rst_n;
  logic                  init_done;
  logic                  mem_busy;
  logic                  load_rd_en;
  logic                  load_queue_empty;
  logic [PIXEL_W:0]      load_queue_data;
  logic                  cmd;
  logic                  cmd_en;
  logic [ADDR_W-1:0]     addr;
  logic [MEM_DATA_W-1:0] wr_data;
  logic                  rd_lock_en;
  logic [2:0]            rd_lock_buf;
  logic                  frame_done;
  logic [2:0]            last_buf;
  logic [2:0]            wr_buf;
  logic                  overrun;
`ifdef FRAME_UPLOADER_STATS_EN
  logic [15:0]           frame_count;
  logic [15:0]           drop_count;
`endif

  frame_uploader_nbuf #(
    .PIXEL_W(PIXEL_W), .MEM_DATA_W(MEM_DATA_W), .BURST_BEATS(BURST_BEATS),
    .NUM_BUFFERS(NUM_BUFFERS), .FRAME_WORDS(FRAME_WORDS), .ADDR_W(ADDR_W),
    .BASE_ADDR(BASE_ADDR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .init_done(init_done), .mem_busy(mem_busy),
    .load_rd_en(load_rd_en), .load_queue_empty(load_queue_empty),
    .load_queue_data(load_queue_data), .cmd(cmd), .cmd_en(cmd_en), .addr(addr),
    .wr_data(wr_data), .rd_lock_en(rd_lock_en), .rd_lock_buf(rd_lock_buf),
    .frame_done(frame_done), .last_buf(last_buf), .wr_buf(wr_buf), .overrun(overrun)
`ifdef FRAME_UPLOADER_STATS_EN
    , .frame_count(frame_count), .drop_count(drop_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Load queue model: one-cycle read latency
  logic [PIXEL_W:0] q_mem [0:1023];
  int               q_head = 0;
  int               q_tail = 0;
  logic [PIXEL_W:0] q_data = '0;
  assign load_queue_empty = (q_head == q_tail);
  assign load_queue_data  = q_data;

  always @(posedge clk) begin
    if (load_rd_en) begin
      q_data <= q_mem[q_head[9:0]];
      q_head <= q_head + 1;
    end
  end

  // Output monitor, sampled mid-cycle
  logic [ADDR_W-1:0]     b_addr [0:255];
  logic [MEM_DATA_W-1:0] b_data [0:255];
  logic                  b_en   [0:255];
  int nb = 0, nfd = 0, nrd = 0, ncmden = 0, viol = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (cmd && nb < 256) begin
        b_addr[nb] = addr;
        b_data[nb] = wr_data;
        b_en[nb]   = cmd_en;
        nb = nb + 1;
      end
      if (frame_done) nfd = nfd + 1;
      if (load_rd_en) nrd = nrd + 1;
      if (cmd_en) ncmden = ncmden + 1;
      if (cmd_en && (mem_busy || !init_done)) viol = viol + 1;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic push_pix(input int v);
    q_mem[q_tail[9:0]] = {1'b0, 16'(v)};
    q_tail = q_tail + 1;
  endtask

  task automatic push_mark();
    q_mem[q_tail[9:0]] = {1'b1, 16'h0000};
    q_tail = q_tail + 1;
  endtask

  task automatic push_run(input int pbase, input int n);
    for (int i = 0; i < n; i++) push_pix(pbase + i);
  endtask

  task automatic wait_fd(input int target, input int budget, input string tag);
    int left;
    left = budget;
    while (nfd < target && left > 0) begin
      @(negedge clk);
      left--;
    end
    check(tag, 64'(nfd), 64'(target));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    q_tail = q_head;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Full two-burst frame: beat k of burst b = {p(16b+2k+1), p(16b+2k)}
  task automatic check_frame(input int s, input int abase, input int pbase, input string tag);
    int p;
    for (int b = 0; b < 2; b++) begin
      for (int k = 0; k < 8; k++) begin
        p = pbase + 16 * b + 2 * k;
        check($sformatf("%s_b%0d_k%0d_addr", tag, b, k), 64'(b_addr[s + 8*b + k]), 64'(abase + 8*b));
        check($sformatf("%s_b%0d_k%0d_data", tag, b, k), 64'(b_data[s + 8*b + k]),
              {32'h0, 16'(p + 1), 16'(p)});
        check($sformatf("%s_b%0d_k%0d_en", tag, b, k), 64'(b_en[s + 8*b + k]), 64'(k == 0));
      end
    end
  endtask

  int s, t, c0, r0;
  logic [31:0] exp_w;

  initial begin
    rst_n       = 1'b0;
    init_done   = 1'b0;
    mem_busy    = 1'b0;
    rd_lock_en  = 1'b0;
    rd_lock_buf = 3'd0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_load_rd_en", 64'(load_rd_en), 64'd0);
    check("rst_cmd",        64'(cmd),        64'd0);
    check("rst_cmd_en",     64'(cmd_en),     64'd0);
    check("rst_addr",       64'(addr),       64'd0);
    check("rst_wr_data",    64'(wr_data),    64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    check("rst_overrun",    64'(overrun),    64'd0);
    check("rst_wr_buf",     64'(wr_buf),     64'd0);
    check("rst_last_buf",   64'(last_buf),   64'd0);

    // No queue read before init_done, even with data waiting
    push_pix(16'hdead);
    push_pix(16'hbeef);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("no_read_before_init", 64'(nrd), 64'd0);
    init_done = 1'b1;

    // Single frame on buffer 0
    s = nb; t = nfd + 1;
    push_mark(); push_run(16'h1000, 32); push_mark();
    wait_fd(t, 1000, "frame0_done");
    check_frame(s, 'h100, 16'h1000, "f0");
    check("f0_beats",    64'(nb - s),  64'd16);
    check("f0_last_buf", 64'(last_buf), 64'd0);
    check("f0_wr_buf",   64'(wr_buf),   64'd1);
    check("f0_overrun",  64'(overrun),  64'd0);

    // Three more frames: buffers 1, 2, then wrap to 0
    s = nb; t = nfd + 3;
    for (int f = 0; f < 3; f++) begin
      push_run(16'h2000 + f * 16'h100, 32);
      push_mark();
    end
    wait_fd(t, 3000, "ring_done");
    check("ring_f1_addr0", 64'(b_addr[s]),      64'h110);
    check("ring_f1_addr1", 64'(b_addr[s + 8]),  64'h118);
    check("ring_f2_addr0", 64'(b_addr[s + 16]), 64'h120);
    check("ring_f2_addr1", 64'(b_addr[s + 24]), 64'h128);
    check("ring_f3_addr0", 64'(b_addr[s + 32]), 64'h100);
    check("ring_f3_addr1", 64'(b_addr[s + 40]), 64'h108);
    check("ring_f3_data0", 64'(b_data[s + 32]), 64'h2201_2200);
    check("ring_wr_buf",   64'(wr_buf),         64'd1);

    // Reader holds buffer 1: frame after buffer 0 goes to buffer 2
    do_reset();
    rd_lock_en = 1'b1; rd_lock_buf = 3'd1;
    s = nb; t = nfd + 1;
    push_mark(); push_run(16'h3000, 32); push_mark();
    wait_fd(t, 1000, "lock_f0_done");
    check("lock_last_buf", 64'(last_buf), 64'd0);
    check("lock_wr_buf",   64'(wr_buf),   64'd2);
    t = nfd + 1;
    push_run(16'h3100, 32); push_mark();
    wait_fd(t, 1000, "lock_f1_done");
    check("lock_f1_addr0", 64'(b_addr[s + 16]), 64'h120);
    check("lock_f1_addr1", 64'(b_addr[s + 24]), 64'h128);
    check("lock_f1_wr_buf", 64'(wr_buf), 64'd0);
    rd_lock_en = 1'b0;

    // Short frame: 5 pixels, zero-padded single burst
    do_reset();
    s = nb; t = nfd + 1;
    push_mark(); push_run(16'h4000, 5); push_mark();
    wait_fd(t, 1000, "short_done");
    repeat (2) @(negedge clk);
    check("short_beats", 64'(nb - s), 64'd8);
    for (int k = 0; k < 8; k++) begin
      case (k)
        0:       exp_w = 32'h4001_4000;
        1:       exp_w = 32'h4003_4002;
        2:       exp_w = 32'h0000_4004;
        default: exp_w = 32'h0;
      endcase
      check($sformatf("short_k%0d_data", k), 64'(b_data[s + k]), 64'(exp_w));
      check($sformatf("short_k%0d_addr", k), 64'(b_addr[s + k]), 64'h100);
      check($sformatf("short_k%0d_en", k),   64'(b_en[s + k]),   64'(k == 0));
    end
    check("short_wr_buf", 64'(wr_buf), 64'd1);

    // Memory busy with full staging: hold off burst and queue reads
    mem_busy = 1'b1;
    s = nb;
    push_run(16'h5000, 17);
    repeat (80) @(negedge clk);
    c0 = ncmden; r0 = nrd;
    repeat (20) @(negedge clk);
    check("busy_no_cmd_en", 64'(ncmden - c0), 64'd0);
    check("busy_no_rd",     64'(nrd - r0),    64'd0);
    check("busy_no_beats",  64'(nb - s),      64'd0);
    check("busy_cmd_en_lo", 64'(cmd_en),      64'd0);
    mem_busy = 1'b0;
    @(negedge clk);
    check("busy_rel_cmd_en", 64'(cmd_en),  64'd1);
    check("busy_rel_cmd",    64'(cmd),     64'd1);
    check("busy_rel_addr",   64'(addr),    64'h110);
    check("busy_rel_data",   64'(wr_data), 64'h5001_5000);
    repeat (20) @(negedge clk);
    check("busy_beats",      64'(nb - s),       64'd8);
    check("busy_beat7_data", 64'(b_data[s + 7]), 64'h500f_500e);

    // Overrun: 40 pixels after one marker, last 8 discarded
    do_reset();
    s = nb; t = nfd + 1;
    push_mark(); push_run(16'h6000, 40);
    wait_fd(t, 1000, "ovr_done");
    check("ovr_clear_at_end", 64'(overrun), 64'd0);
    repeat (60) @(negedge clk);
    check("ovr_set",   64'(overrun), 64'd1);
    check("ovr_beats", 64'(nb - s),  64'd16);
`ifdef FRAME_UPLOADER_STATS_EN
    check("ovr_drop_count",  64'(drop_count),  64'd8);
    check("ovr_frame_count", 64'(frame_count), 64'd1);
`endif

    // Asynchronous reset in the middle of a burst
    push_mark(); push_run(16'h7000, 16);
    t = 400;
    while (!(cmd && !cmd_en) && t > 0) begin
      @(negedge clk);
      t--;
    end
    check("mid_burst_seen", 64'(cmd), 64'd1);
    check("mid_burst_buf",  64'(wr_buf), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_cmd",        64'(cmd),        64'd0);
    check("mrst_cmd_en",     64'(cmd_en),     64'd0);
    check("mrst_addr",       64'(addr),       64'd0);
    check("mrst_wr_data",    64'(wr_data),    64'd0);
    check("mrst_load_rd_en", 64'(load_rd_en), 64'd0);
    check("mrst_frame_done", 64'(frame_done), 64'd0);
    check("mrst_overrun",    64'(overrun),    64'd0);
    check("mrst_wr_buf",     64'(wr_buf),     64'd0);
    check("mrst_last_buf",   64'(last_buf),   64'd0);
    q_tail = q_head;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    check("cmd_en_while_busy", 64'(viol), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/frame_uploader_nbuf.md
FRAME_UPLOADER_NBUF -- requirements
Module: frame_uploader_nbuf

Interface
REQ-001 SHALL have parameter PIXEL_W, default 16, camera pixel width; queue word is PIXEL_W+1 bits.
REQ-002 SHALL have parameter MEM_DATA_W, default 32, memory word width; integer multiple of PIXEL_W (PPW = MEM_DATA_W/PIXEL_W).
REQ-003 SHALL have parameter BURST_BEATS, default 8, memory words per write burst.
REQ-004 SHALL have parameter NUM_BUFFERS, default 3, frame buffers in ring, range 2..8.
REQ-005 SHALL have parameter FRAME_WORDS, default 38400, memory words per frame; multiple of BURST_BEATS.
REQ-006 SHALL have parameters ADDR_W, default 21, and BASE_ADDR, default 0, word address of buffer 0.
REQ-007 SHALL have ports: clk in 1, single clock; rst_n in 1, asynchronous active-low reset.
REQ-008 SHALL have ports: init_done in 1, memory ready; mem_busy in 1, controller cannot accept cmd_en.
REQ-009 SHALL have ports: load_rd_en out 1; load_queue_empty in 1; load_queue_data in PIXEL_W+1, bit PIXEL_W = start-of-frame marker.
REQ-010 SHALL have ports: cmd out 1 (1 = write); cmd_en out 1; addr out ADDR_W; wr_data out MEM_DATA_W.
REQ-011 SHALL have ports: rd_lock_en in 1, rd_lock_buf in 3, buffer held by reader; frame_done out 1; last_buf out 3; wr_buf out 3; overrun out 1.

Function
REQ-012 SHALL implement FSM IDLE -> WAIT_SOF -> FILL -> BURST -> FILL/FRAME_END -> WAIT_SOF or FILL.
REQ-013 IDLE: load_rd_en=0 until init_done=1, then WAIT_SOF.
REQ-014 Queue read latency is one cycle: data captured on the clk edge after a cycle with load_rd_en=1; load_rd_en=1 only when !load_queue_empty and staging has room counting in-flight reads.
REQ-015 WAIT_SOF: pixel words discarded; marker word -> FILL, burst index 0.
REQ-016 FILL: pixels packed LSB-first, PPW per word, into staging of BURST_BEATS words; staging full -> BURST.
REQ-017 BURST: waits mem_busy=0, then drives BURST_BEATS consecutive beats: cmd=1, addr = BASE_ADDR + wr_buf*FRAME_WORDS + burst_index*BURST_BEATS held all beats, cmd_en=1 first beat only, wr_data word 0..N-1 in order.
REQ-018 Burst end: burst_index increments; reaching FRAME_WORDS/BURST_BEATS -> FRAME_END, else FILL.
REQ-019 Marker in FILL with empty staging -> FRAME_END; with partial staging -> zero-pad remainder, issue burst, then FRAME_END.
REQ-020 Pixels after frame full and before next marker SHALL be discarded and set overrun (sticky until reset).
REQ-021 FRAME_END: frame_done one-cycle pulse, last_buf=wr_buf, wr_buf=(wr_buf+1) mod NUM_BUFFERS; if rd_lock_en and result==rd_lock_buf, advance once more; if the marker ended the frame -> FILL, else WAIT_SOF.
REQ-022 cmd_en SHALL never assert while mem_busy=1 or init_done=0.

Reset
REQ-023 rst_n=0 SHALL immediately force IDLE and clear load_rd_en, cmd, cmd_en, addr, wr_data, frame_done, overrun, wr_buf, last_buf, staging and counters to 0, including mid-burst.
REQ-024 After rst_n release, no queue read before init_done=1.

Configuration
REQ-025 With FRAME_UPLOADER_STATS_EN defined SHALL add outputs frame_count (16 bits, +1 per frame_done, wraps) and drop_count (16 bits, +1 per discarded pixel, saturates at 0xFFFF); undefined SHALL omit these ports and logic.

Verification (PIXEL_W=16, MEM_DATA_W=32, BURST_BEATS=8, NUM_BUFFERS=3, FRAME_WORDS=16, BASE_ADDR=0x100)
REQ-026 Marker, 32 pixels p0..p31, marker -> bursts at addr 0x100 and 0x108, beat k = {p2k+1,p2k} per burst, cmd_en first beat only, frame_done, last_buf=0, wr_buf=1.
REQ-027 Three full frames -> buffer bases 0x100, 0x110, 0x120, then wrap to 0x100.
REQ-028 rd_lock_en=1, rd_lock_buf=1 during frame on buffer 0 -> next frame written at 0x120, wr_buf=2.
REQ-029 Marker, 5 pixels, marker -> one burst at 0x100, beats 0-1 data, beat 2 = {0,p4}, beats 3-7 zero, frame_done.
REQ-030 mem_busy=1 for 20 cycles with full staging -> cmd_en held low, load_rd_en low, burst starts the cycle after mem_busy falls.
REQ-031 40 pixels without marker after frame start -> overrun=1, 8 pixels dropped (drop_count=8 with FRAME_UPLOADER_STATS_EN); rst_n pulse mid-burst -> all outputs 0 within same cycle.
